adj_clock_period_detector: RTL and testbench

- Receive-side counterpart of the adjustable clock divider: measures the toggle interval of a slow, divider-generated clock and reports it in local clock cycles.
- Synchronises the incoming signal, counts cycles between its edges, reports each half-period and asserts lock once consecutive measurements agree.
- Used for checking divided clocks, recovering the division factor, and detecting loss of clock.

---
 rtl/adj_clock_period_detector.sv | 154 +++++++++++++++
 tb/tb_adj_clock_period_detector.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/adj_clock_period_detector.sv
// Measures the toggle interval of a slow, divider-generated clock in local clock cycles,
// reports each half-period, asserts Locked once successive measurements agree, and flags loss of clock.
module adj_clock_period_detector #(
  parameter int COUNTER_BIT_WIDTH = 16,
  parameter int SYNC_STAGES       = 2,
  parameter int LOCK_COUNT        = 4,
  parameter int TOLERANCE         = 1
) (
  input  logic                         ClkInput,
  input  logic                         ResetN,
  input  logic                         SigInput,
  input  logic                         Enable,
  output logic [COUNTER_BIT_WIDTH-1:0] HalfPeriod,
  output logic                         HalfPeriodValid,
  output logic                         Locked,
  output logic                         Timeout
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [COUNTER_BIT_WIDTH-1:0] LP_MAX  = '1;
  localparam logic [COUNTER_BIT_WIDTH:0]   LP_TOL  = (COUNTER_BIT_WIDTH+1)'(TOLERANCE);
  localparam logic [MW-1:0]                LP_LOCK = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_LOCKED} state_t;

  logic [SYNC_STAGES-1:0]       r_sync;
  logic                         r_prev;
  state_t                       r_state, w_state_nxt;
  logic [COUNTER_BIT_WIDTH-1:0] r_count, w_count_nxt;
  logic [COUNTER_BIT_WIDTH-1:0] r_half, w_half_nxt;
  logic [MW-1:0]                r_match, w_match_nxt;
  logic                         r_valid, w_valid_nxt;
  logic                         r_locked, w_locked_nxt;
  logic                         r_timeout, w_timeout_nxt;
  logic                         r_have_prev, w_have_prev_nxt;

  logic                         w_edge;
  logic [COUNTER_BIT_WIDTH:0]   w_new, w_old, w_diff;
  logic                         w_agree;
  logic [MW-1:0]                w_match_inc;

  // NOTE: async reset in the sensitivity list, and <= for every sequential update so all flops
  // sample the pre-edge values regardless of statement order.
  always_ff @(posedge ClkInput or negedge ResetN) begin
    if (!ResetN) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], SigInput};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Both polarities of the synchronised signal count as an edge.
  assign w_edge      = r_sync[SYNC_STAGES-1] ^ r_prev;
  assign w_new       = {1'b0, r_count};
  assign w_old       = {1'b0, r_half};
  assign w_diff      = (w_new >= w_old) ? (w_new - w_old) : (w_old - w_new);
  assign w_agree     = (w_diff <= LP_TOL);
  assign w_match_inc = r_match + MW'(1);

  // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_half_nxt      = r_half;
    w_match_nxt     = r_match;
    w_valid_nxt     = 1'b0;
    w_locked_nxt    = r_locked;
    w_timeout_nxt   = r_timeout;
    w_have_prev_nxt = r_have_prev;

    if (!Enable) begin
      w_state_nxt     = S_IDLE;
      w_count_nxt     = '0;
      w_match_nxt     = '0;
      w_locked_nxt    = 1'b0;
      w_timeout_nxt   = 1'b0;
      w_have_prev_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_count_nxt = '0;
          if (w_edge) begin
            w_state_nxt     = S_MEASURE;
            w_count_nxt     = COUNTER_BIT_WIDTH'(1);
            w_match_nxt     = '0;
            w_timeout_nxt   = 1'b0;
            w_have_prev_nxt = 1'b0;
          end
        end
        default: begin
          if (w_edge) begin
            w_half_nxt      = r_count;
            w_valid_nxt     = 1'b1;
            w_count_nxt     = COUNTER_BIT_WIDTH'(1);
            w_have_prev_nxt = 1'b1;
            // The first capture after IDLE has nothing to compare against.
            if (r_have_prev && w_agree) begin
              if (r_state != S_LOCKED) begin
                if (w_match_inc == LP_LOCK) begin
                  w_state_nxt  = S_LOCKED;
                  w_locked_nxt = 1'b1;
                end
                w_match_nxt = w_match_inc;
              end
            end else if (r_have_prev) begin
              w_state_nxt  = S_MEASURE;
              w_match_nxt  = '0;
              w_locked_nxt = 1'b0;
            end
          end else if (r_count == LP_MAX) begin
            w_state_nxt     = S_IDLE;
            w_count_nxt     = '0;
            w_match_nxt     = '0;
            w_locked_nxt    = 1'b0;
            w_timeout_nxt   = 1'b1;
            w_have_prev_nxt = 1'b0;
          end else begin
            w_count_nxt = r_count + COUNTER_BIT_WIDTH'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge ClkInput or negedge ResetN) begin
    if (!ResetN) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_half      <= '0;
      r_match     <= '0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_timeout   <= 1'b0;
      r_have_prev <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_half      <= w_half_nxt;
      r_match     <= w_match_nxt;
      r_valid     <= w_valid_nxt;
      r_locked    <= w_locked_nxt;
      r_timeout   <= w_timeout_nxt;
      r_have_prev <= w_have_prev_nxt;
    end
  end

  assign HalfPeriod      = r_half;
  assign HalfPeriodValid = r_valid;
  assign Locked          = r_locked;
  assign Timeout         = r_timeout;

endmodule

// File: tb/tb_adj_clock_period_detector.sv
// Bench for adj_clock_period_detector: directed and randomized toggle schedules checked every cycle
// against an interval-level model (measurement = gap between toggles, lock = trailing agreeing pairs).
module tb_adj_clock_period_detector;

  localparam int CW   = 8;
  localparam int SS   = 2;
  localparam int LC   = 4;
  localparam int TOL  = 1;
  localparam int MAXC = (1 << CW) - 1;
  localparam int LAT  = SS + 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          sig   = 1'b0;
  logic          en    = 1'b0;
  logic [CW-1:0] half;
  logic          valid, locked, timeout;

  always #5 clk = ~clk;

  adj_clock_period_detector #(
    .COUNTER_BIT_WIDTH(CW),
    .SYNC_STAGES      (SS),
    .LOCK_COUNT       (LC),
    .TOLERANCE        (TOL)
  ) dut (
    .ClkInput       (clk),
    .ResetN         (rst_n),
    .SigInput       (sig),
    .Enable         (en),
    .HalfPeriod     (half),
    .HalfPeriodValid(valid),
    .Locked         (locked),
    .Timeout        (timeout)
  );

  int total = 0;
  int bad   = 0;

  // Model state: time is counted in sampling negedges.
  int n      = 0;
  int due_q[$];
  int meas[$];
  int plan[$];
  int since  = 1000;
  bit m_idle = 1'b1;
  int m_last = 0;
  int e_half = 0;
  bit e_valid, e_locked, e_timeout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic int trailing_agree();
    int k = 0;
    for (int i = meas.size() - 1; i >= 1; i--) begin
      int d = meas[i] - meas[i-1];
      if (d < 0) d = -d;
      if (d <= TOL) k++;
      else break;
    end
    return k;
  endfunction

  // One cycle: update the model, compare all outputs, then drive the next toggle from the plan.
  task automatic tick();
    bit edge_now;
    @(negedge clk);
    n++;
    edge_now = 1'b0;
    if (due_q.size() > 0 && due_q[0] == n) begin
      void'(due_q.pop_front());
      edge_now = 1'b1;
    end
    e_valid = 1'b0;
    if (!en) begin
      m_idle = 1'b1; e_locked = 1'b0; e_timeout = 1'b0;
      meas.delete();
    end else if (edge_now) begin
      if (m_idle) begin
        m_idle = 1'b0; e_timeout = 1'b0;
        meas.delete();
      end else begin
        meas.push_back(n - m_last);
        e_half   = n - m_last;
        e_valid  = 1'b1;
        e_locked = (trailing_agree() >= LC);
      end
      m_last = n;
    end else if (!m_idle && (n - m_last) == MAXC) begin
      m_idle = 1'b1; e_timeout = 1'b1; e_locked = 1'b0;
      meas.delete();
    end
    check("valid",   valid,   e_valid);
    check("half",    half,    e_half);
    check("locked",  locked,  e_locked);
    check("timeout", timeout, e_timeout);
    since++;
    if (plan.size() > 0 && since >= plan[0]) begin
      sig = ~sig;
      void'(plan.pop_front());
      since = 0;
      due_q.push_back(n + LAT);
    end
  endtask

  task automatic drain();
    while (plan.size() > 0) tick();
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_half",    half,    0);
    check("rst_valid",   valid,   0);
    check("rst_locked",  locked,  0);
    check("rst_timeout", timeout, 0);
    sig = 1'b0;
    since = 1000;
    plan.delete(); due_q.delete(); meas.delete();
    m_idle = 1'b1; e_half = 0; e_valid = 1'b0; e_locked = 1'b0; e_timeout = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("init_half",    half,    0);
    check("init_valid",   valid,   0);
    check("init_locked",  locked,  0);
    check("init_timeout", timeout, 0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Reference divider with factor 9 toggles every 10 cycles.
    repeat (12) plan.push_back(10);
    drain();
    repeat (LAT + 1) tick();
    check("div_half",   half,   10);
    check("div_locked", locked, 1);

    // Alternating 10/11 stays locked; a 13 breaks lock, then it re-locks.
    repeat (6) begin plan.push_back(10); plan.push_back(11); end
    plan.push_back(13);
    repeat (4) begin plan.push_back(10); plan.push_back(11); end
    drain();
    repeat (LAT + 1) tick();
    check("alt_relocked", locked, 1);

    // Saturation boundary: an interval of exactly all-ones is a valid capture, not a timeout.
    plan.push_back(10); plan.push_back(MAXC); plan.push_back(10);
    drain();
    repeat (LAT + 1) tick();
    check("sat_timeout", timeout, 0);

    // Frozen input: timeout, then the first toggle only restarts and the second measures.
    repeat (8) plan.push_back(10);
    drain();
    repeat (MAXC + LAT + 5) tick();
    check("to_timeout", timeout, 1);
    check("to_locked",  locked,  0);
    check("to_half",    half,    10);
    repeat (10) plan.push_back(10);
    drain();
    repeat (LAT + 1) tick();
    check("to_cleared", timeout, 0);

    // Enable dropped for three cycles while locked.
    repeat (20) plan.push_back(10);
    repeat (60) tick();
    en = 1'b0;
    repeat (3) tick();
    check("en_locked", locked, 0);
    check("en_half",   half,   10);
    en = 1'b1;
    drain();
    repeat (LAT + 1) tick();

    // Asynchronous reset mid-interval, then a fresh measurement run.
    repeat (10) plan.push_back(10);
    repeat (37) tick();
    async_reset();
    repeat (10) plan.push_back(10);
    drain();
    repeat (LAT + 1) tick();
    check("rst_relock", locked, 1);

    // Input toggling every clock cycle.
    repeat (20) plan.push_back(1);
    drain();
    repeat (LAT + 1) tick();
    check("fast_half",   half,   1);
    check("fast_locked", locked, 1);

    // Randomized schedules with occasional jumps and Enable drops.
    for (int k = 0; k < 3000; k++) begin
      if (plan.size() == 0) begin
        int base = int'($urandom_range(1, 25));
        repeat ($urandom_range(3, 10)) plan.push_back(base + int'($urandom_range(0, 1)));
        if ($urandom_range(0, 4) == 0) plan.push_back(int'($urandom_range(1, 40)));
      end
      if ($urandom_range(0, 299) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 2) == 0) en = 1'b1;
      tick();
    end
    en = 1'b1;
    repeat (LAT + 2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
